pe_output_collector: RTL

Synthesizable receiver for the luma processing element output stream. Samples the 17-bit `o`/`Vout` result stream and rounds/clips each sample to a prediction pixel (uni-pred) or saturates it to a 16-bit intermediate (bi-pred). Packs the results into 32-bit words and buffers them in a small FIFO behind a valid/ready interface toward the frame-memory writer. It replaces the behavioural sink at the PE output in the hardware datapath.

---
 rtl/pe_collect_pkg.sv | 26 ++
 rtl/pe_collect_fifo.sv | 55 +++++
 rtl/pe_output_collector.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pe_collect_pkg.sv
// Shared widths, rounding constants, clip bounds and FIFO entry type
// for the luma PE output collector.
package pe_collect_pkg;

  localparam int PE_OUT_W   = 17;
  localparam int WORD_W     = 32;
  localparam int UNI_SHIFT  = 6;
  localparam int UNI_OFFSET = 32;

  localparam logic signed [17:0] UNI_MIN = 18'sd0;
  localparam logic signed [17:0] UNI_MAX = 18'sd255;
  localparam logic signed [17:0] BI_MIN  = -18'sd32768;
  localparam logic signed [17:0] BI_MAX  = 18'sd32767;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [3:0]        keep;
    logic              last;
  } fifo_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_t;

endpackage

// File: rtl/pe_collect_fifo.sv
// First-word fall-through FIFO of packed words; head reads as zero
// while empty.
module pe_collect_fifo
  import pe_collect_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // a pop frees the slot the push lands in when full
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pe_output_collector.sv
// Rounds/clips PE samples, packs them into 32-bit words, buffers in a FIFO.
// Optional saturation counter: define PE_COLLECT_SAT_CNT_EN.
module pe_output_collector
  import pe_collect_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                Vin,
  input  logic [PE_OUT_W-1:0] InData,
  input  logic                bi_pred,
  input  logic                blk_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [3:0]          out_keep,
  output logic                out_last,
  output logic                overflow
`ifdef PE_COLLECT_SAT_CNT_EN
  ,
  output logic [15:0]         sat_cnt
`endif
);

  logic signed [17:0] ext;
  logic signed [17:0] ofs;
  logic signed [17:0] sh;
  logic [1:0]         in_lp;
  logic               in_bi;
  logic               eff_bi;
  logic               in_full;
  logic [15:0]        p;
  logic               sat;

  logic        s1_valid;
  logic [15:0] s1_p;
  logic        s1_last;
  logic        s1_bi;
  logic        s1_sat;

  assign ext = {InData[PE_OUT_W-1], InData};
  assign ofs = 18'(UNI_OFFSET);
  assign sh  = (ext + ofs) >>> UNI_SHIFT;

  // word mode is chosen by the first sample and held so rounding matches packing
  assign eff_bi  = (in_lp == 2'd0) ? bi_pred : in_bi;
  assign in_full = eff_bi ? (in_lp == 2'd1) : (in_lp == 2'd3);

  always_comb begin
    p   = '0;
    sat = 1'b0;
    unique case (1'b1)
      eff_bi: begin
        if (ext < BI_MIN) begin
          p   = BI_MIN[15:0];
          sat = 1'b1;
        end else if (ext > BI_MAX) begin
          p   = BI_MAX[15:0];
          sat = 1'b1;
        end else begin
          p = ext[15:0];
        end
      end
      !eff_bi: begin
        if (sh < UNI_MIN) begin
          p   = {8'b0, UNI_MIN[7:0]};
          sat = 1'b1;
        end else if (sh > UNI_MAX) begin
          p   = {8'b0, UNI_MAX[7:0]};
          sat = 1'b1;
        end else begin
          p = {8'b0, sh[7:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_last  <= 1'b0;
      s1_bi    <= 1'b0;
      in_lp    <= '0;
      in_bi    <= 1'b0;
    end else begin
      s1_valid <= Vin;
      if (Vin) begin
        s1_p    <= p;
        s1_last <= blk_last;
        s1_bi   <= eff_bi;
        in_bi   <= eff_bi;
        in_lp   <= (in_full || blk_last) ? 2'd0 : in_lp + 2'd1;
      end
    end
  end

`ifdef PE_COLLECT_SAT_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s1_sat <= 1'b0;
    else if (Vin) s1_sat <= sat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt <= '0;
    end else if (s1_valid && s1_sat && sat_cnt != 16'hFFFF) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  assign s1_sat = 1'b0;
  logic unused_sat;
  assign unused_sat = &{1'b0, sat, s1_sat};
`endif

  pack_state_t       state;
  logic [1:0]        lp;
  logic              word_bi;
  logic [WORD_W-1:0] data_q;
  logic [3:0]        keep_q;
  logic              mode;
  logic              full_lane;
  logic              close;
  logic [WORD_W-1:0] wdata;
  logic [3:0]        wkeep;
  logic              push_q;
  fifo_entry_t       push_entry;

  assign mode      = (state == IDLE) ? s1_bi : word_bi;
  assign full_lane = mode ? (lp == 2'd1) : (lp == 2'd3);
  assign close     = s1_valid && (full_lane || s1_last);

  always_comb begin
    wdata = data_q;
    wkeep = keep_q;
    unique case (1'b1)
      mode: begin
        wdata = data_q | ({16'b0, s1_p} << {lp[0], 4'b0000});
        wkeep = keep_q | (4'b0011 << {lp[0], 1'b0});
      end
      !mode: begin
        wdata = data_q | ({24'b0, s1_p[7:0]} << {lp, 3'b000});
        wkeep = keep_q | (4'b0001 << lp);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lp         <= '0;
      word_bi    <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      push_q     <= 1'b0;
      push_entry <= '0;
    end else begin
      push_q <= close;
      if (close) push_entry <= '{data: wdata, keep: wkeep, last: s1_last};
      if (s1_valid) begin
        if (close) begin
          state  <= IDLE;
          lp     <= '0;
          data_q <= '0;
          keep_q <= '0;
        end else begin
          state  <= FILL;
          lp     <= lp + 2'd1;
          data_q <= wdata;
          keep_q <= wkeep;
          if (state == IDLE) word_bi <= s1_bi;
        end
      end
    end
  end

  fifo_entry_t head;
  logic        f_full;
  logic        f_empty;
  logic        pop;

  assign out_valid = !f_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = head.data;
  assign out_keep  = head.keep;
  assign out_last  = head.last;

  pe_collect_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_q),
    .din     (push_entry),
    .pop     (pop),
    .dout    (head),
    .full    (f_full),
    .empty   (f_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow <= 1'b0;
    else if (push_q && f_full && !pop) overflow <= 1'b1;
  end

endmodule
